// File: rtl/inst_fetch_resp_pkg.sv
// Shared fetch-side constants and the fetch responder state encoding.
package inst_fetch_resp_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic {
    FetchIdle = 1'b0,
    FetchWait = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_resp_if.sv
// Instruction memory bus: one outstanding word request, single-cycle ack.
interface inst_fetch_resp_if;
  import inst_fetch_resp_pkg::*;

  logic                   req;
  logic [InstAddrBus-1:0] addr;
  logic [InstBus-1:0]     rdata;
  logic                   ack;

  modport master (output req, output addr, input rdata, input ack);
  modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: one-word hit buffer, refilled from memory on a miss
// with a bounded wait; a timed-out fetch is buffered as a NOP and flagged.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ce,
  input  logic [InstAddrBus-1:0]   i_pc,
  output logic [InstBus-1:0]       o_inst,
  output logic                     o_stallreq,
  output logic                     o_fetch_err,
  inst_fetch_resp_if.master        mem
);
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e           r_state;
  logic                   r_mem_req;
  logic [InstAddrBus-1:0] r_mem_addr;
  logic                   r_buf_valid;
  logic [29:0]            r_buf_addr;
  logic [InstBus-1:0]     r_buf_data;
  logic [7:0]             r_cnt;
  logic                   r_fetch_err;

  logic w_hit;
  logic w_miss;
  logic w_unused_pc_lsb;

  // Byte offset within the word never affects the fetch.
  assign w_unused_pc_lsb = ^i_pc[1:0];

  assign w_hit  = (i_ce == ChipEnable) && r_buf_valid && (r_buf_addr == i_pc[31:2]);
  assign w_miss = (i_ce == ChipEnable) && !w_hit;

  assign o_inst      = (r_state == FetchIdle && w_hit) ? r_buf_data : ZeroWord;
  assign o_stallreq  = (r_state == FetchWait) || w_miss;
  assign o_fetch_err = r_fetch_err;
  assign mem.req     = r_mem_req;
  assign mem.addr    = r_mem_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst == RstEnable) begin
      r_state     <= FetchIdle;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= ZeroWord;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= 1'b0;
      case (r_state)
        FetchIdle: begin
          if (w_miss) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {i_pc[31:2], 2'b00};
            r_cnt      <= '0;
            r_state    <= FetchWait;
          end
        end
        FetchWait: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (mem.ack) begin
            r_buf_data  <= mem.rdata;
            r_buf_addr  <= r_mem_addr[31:2];
            r_buf_valid <= 1'b1;
            r_mem_req   <= 1'b0;
            r_state     <= FetchIdle;
          end else if (r_cnt == CntLast) begin
            r_buf_data  <= ZeroWord;
            r_buf_addr  <= r_mem_addr[31:2];
            r_buf_valid <= 1'b1;
            r_mem_req   <= 1'b0;
            r_fetch_err <= 1'b1;
            r_state     <= FetchIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= FetchIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp with TIMEOUT_CYCLES=4 and a hand-driven memory.
module tb_inst_fetch_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        stallreq;
  logic        fetch_err;
  int          n_chk = 0;
  int          n_fail = 0;

  inst_fetch_resp_if mem_if ();

  inst_fetch_resp #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ce        (ce),
    .i_pc        (pc),
    .o_inst      (inst),
    .o_stallreq  (stallreq),
    .o_fetch_err (fetch_err),
    .mem         (mem_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int n_req;
    int n_stall;
    rst = 1'b1; ce = 1'b0; pc = '0;
    mem_if.ack = 1'b0; mem_if.rdata = '0;
    nxt(); nxt();

    // Reset state
    smp();
    chk("rst_inst", inst, 32'h0);
    chk("rst_stall_ce0", {31'b0, stallreq}, 32'd0);
    chk("rst_req", {31'b0, mem_if.req}, 32'd0);
    chk("rst_addr", mem_if.addr, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    nxt();
    ce = 1'b1;
    smp();
    chk("rst_stall_ce1", {31'b0, stallreq}, 32'd1);
    nxt();
    rst = 1'b0;

    // Miss at 0x0, ack on the 3rd edge after req rises: stall for 4 cycles
    n_stall = 0;
    for (int c = 0; c < 4; c++) begin
      mem_if.ack = (c == 3);
      mem_if.rdata = (c == 3) ? 32'h3C010101 : 32'h0;
      smp();
      if (stallreq) n_stall++;
      if (c == 2) begin
        chk("miss0_req", {31'b0, mem_if.req}, 32'd1);
        chk("miss0_addr", mem_if.addr, 32'h0);
        chk("miss0_inst", inst, 32'h0);
      end
      nxt();
    end
    mem_if.ack = 1'b0; mem_if.rdata = '0;
    chk("miss0_stall_cycles", n_stall, 32'd4);
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("hold0_inst", inst, 32'h3C010101);
      chk("hold0_stall", {31'b0, stallreq}, 32'd0);
      chk("hold0_req", {31'b0, mem_if.req}, 32'd0);
      nxt();
    end

    // Fill 0x4 with k=1, then pc=0x6 hits
    pc = 32'h4;
    smp(); nxt();
    mem_if.ack = 1'b1; mem_if.rdata = 32'h11223344;
    smp();
    chk("fill4_addr", mem_if.addr, 32'h4);
    nxt();
    mem_if.ack = 1'b0; mem_if.rdata = '0;
    pc = 32'h6;
    smp();
    chk("lsb_hit_inst", inst, 32'h11223344);
    chk("lsb_hit_stall", {31'b0, stallreq}, 32'd0);
    nxt();
    smp();
    chk("lsb_hit_noreq", {31'b0, mem_if.req}, 32'd0);
    nxt();

    // Timeout: memory never acks
    pc = 32'h100;
    smp(); nxt();
    n_req = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (!mem_if.req) break;
      n_req++;
      nxt();
    end
    chk("to_req_cycles", n_req, 32'd4);
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_inst", inst, 32'h0);
    chk("to_stall", {31'b0, stallreq}, 32'd0);
    nxt();
    smp();
    chk("to_err_pulse", {31'b0, fetch_err}, 32'd0);
    chk("to_noreq", {31'b0, mem_if.req}, 32'd0);
    nxt();

    // Ack on the final timeout cycle wins
    pc = 32'h200;
    smp(); nxt();
    for (int c = 0; c < 4; c++) begin
      mem_if.ack = (c == 3);
      mem_if.rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
      smp();
      nxt();
    end
    mem_if.ack = 1'b0; mem_if.rdata = '0;
    smp();
    chk("race_inst", inst, 32'hDEADBEEF);
    chk("race_err", {31'b0, fetch_err}, 32'd0);
    chk("race_stall", {31'b0, stallreq}, 32'd0);
    nxt();

    // Reset mid-WAIT, then a stray ack in IDLE
    pc = 32'h300;
    smp(); nxt();
    smp();
    chk("rstw_req_before", {31'b0, mem_if.req}, 32'd1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0; ce = 1'b0;
    smp();
    chk("rstw_req_after", {31'b0, mem_if.req}, 32'd0);
    mem_if.ack = 1'b1; mem_if.rdata = 32'h00000055;
    nxt();
    mem_if.ack = 1'b0; mem_if.rdata = '0;
    ce = 1'b1;
    smp();
    chk("rstw_stray_stall", {31'b0, stallreq}, 32'd1);
    chk("rstw_stray_inst", inst, 32'h0);
    pc = 32'h200;
    #1;
    chk("rstw_inval_old", {31'b0, stallreq}, 32'd1);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder on the memory side of the PC generator. It accepts the fetch address `pc` and enable `ce`, and returns `inst` from a one-word hit buffer. On a miss it runs a variable-latency req/ack transaction to external instruction memory and holds the pipeline through `stallreq`, which goes to `ctrl` and drives `stall[0]`. It sits between the PC register, the IF/ID stage and the instruction memory bus.

## Interface
- `TIMEOUT_CYCLES`, default 64: number of WAIT cycles without `mem_ack` before the fetch is abandoned; legal range 2..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `ce`  in  1  fetch enable from the PC register (`ChipEnable`/`ChipDisable`).
- `pc`  in  `InstAddrBus` (32)  fetch byte address.
- `inst`  out  `InstBus` (32)  instruction for the IF/ID stage; combinational.
- `stallreq`  out  1  fetch-stall request to `ctrl`; combinational.
- `fetch_err`  out  1  registered one-cycle pulse on timeout.
- `mem_req`  out  1  memory request; registered.
- `mem_addr`  out  32  word-aligned request address; registered.
- `mem_rdata`  in  32  memory read data; valid only when `mem_ack`=1.
- `mem_ack`  in  1  single-cycle completion strobe.

## Operation
- Word address is `{pc[31:2],2'b00}`. `pc[1:0]` is ignored.
- Buffer holds `buf_valid`, `buf_addr[31:2]` and `buf_data`. A hit is `ce`=1 & `buf_valid` & `buf_addr`==`pc[31:2]`.
- State IDLE:
  - `ce`=0: `inst`=0, `stallreq`=0, no request issued.
  - Hit: `inst`=`buf_data`, `stallreq`=0.
  - Miss: `inst`=0, `stallreq`=1. Next edge: `mem_req`←1, `mem_addr`←word address, timeout counter ←0, state→WAIT.
- State WAIT:
  - `stallreq`=1 and `inst`=0 regardless of `ce` or `pc`.
  - `mem_req` and `mem_addr` are held stable.
  - Counter increments each cycle.
  - `mem_ack`=1: `buf_data`←`mem_rdata`, `buf_addr`←`mem_addr[31:2]`, `buf_valid`←1, `mem_req`←0, state→IDLE.
  - Counter reaches `TIMEOUT_CYCLES`-1 without ack: `buf_data`←0 (NOP), `buf_addr`←`mem_addr[31:2]`, `buf_valid`←1, `mem_req`←0, `fetch_err`←1 for one cycle, state→IDLE.
- `mem_ack` and timeout on the same edge: the ack wins and `fetch_err` stays 0.
- `mem_ack` while in IDLE is ignored.
- A `pc` change or `ce` drop during WAIT does not abort the transaction. The result is still buffered under `mem_addr`. The new `pc` then misses in IDLE and starts a fresh fetch.

## Timing
- Reset values: state=IDLE, `mem_req`=0, `mem_addr`=0, `buf_valid`=0, `buf_addr`=0, `buf_data`=0, counter=0, `fetch_err`=0. Combinational outputs therefore read `inst`=0 and `stallreq` follows `ce` (miss).
- Reset during WAIT drops `mem_req` on that edge and invalidates the buffer.
- Hit latency: 0 cycles, with `inst` valid in the same cycle as `pc`.
- Miss with ack arriving k cycles after `mem_req` rises (k≥1): `stallreq` is high for k+1 cycles. `inst` is valid in the cycle after the ack edge, with `stallreq`=0.
- Timeout: `mem_req` is high for exactly `TIMEOUT_CYCLES` cycles. `inst`=0 with `stallreq`=0 is presented in the cycle after the drop, coincident with `fetch_err`=1.
- Only one outstanding request. `mem_req` never rises in the same cycle it falls.

## Structure
- New constants go in the shared defines file: `FetchIdle`, `FetchWait` state encodings, and `ZeroWord` if absent.
- Reuse the existing `InstAddrBus`, `InstBus`, `RstEnable` and `ChipEnable` defines.
- Single module, no sub-modules. The hit buffer is three registers, not a separate memory.

## Test plan
- Reset, then `ce`=1, `pc`=0x0 with memory ack latency 3 and data 0x3C010101 -> `stallreq` high 4 cycles, `mem_addr`=0x0. Next cycle `inst`=0x3C010101, `stallreq`=0.
- Hold `pc`=0x0 after the fill -> `inst`=0x3C010101 every cycle, `mem_req` stays 0.
- `pc`=0x6 after a fill of 0x4 -> hit, with no request issued (low address bits ignored).
- `TIMEOUT_CYCLES`=4 and memory never acks -> `mem_req` high 4 cycles, then `fetch_err` pulses once with `inst`=0 and `stallreq`=0.
- `mem_ack` on the final timeout cycle -> data buffered and `fetch_err` stays 0. Separately, `rst` asserted mid-WAIT -> `mem_req`=0 next edge, and a later ack in IDLE leaves `buf_valid`=0.
